// File: rtl/rstb_seq_pkg.sv
// Shared definitions for the reset sequencer slice.
//   seq_state_e : sequencer state encoding (HOLD, GAP, RUN, SOFT)
//   cnt_width() : width of the hold/stagger counter, sized so the larger
//                 terminal count fits with one spare bit.
package rstb_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_GAP  = 2'd1,
        ST_RUN  = 2'd2,
        ST_SOFT = 2'd3
    } seq_state_e;

    function automatic int cnt_width(input int hold, input int stagger);
        int m;
        m = (hold > stagger) ? hold : stagger;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/rstb_rr_arbiter.sv
// Combinational round-robin pick for soft-reset requests.
//   req   : per-domain request level
//   ptr   : index with highest priority this cycle
//   grant : first requesting index at or after ptr (wrapping)
//   valid : at least one request is present
module rstb_rr_arbiter #(
    parameter int N_DOM = 4,
    parameter int IW    = 2
) (
    input  logic [N_DOM-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [IW-1:0]    grant,
    output logic             valid
);

    always_comb begin
        int          cand;
        logic [IW-1:0] cidx;
        grant = '0;
        valid = 1'b0;
        cand  = 0;
        cidx  = '0;
        // Walk from the farthest offset down so the nearest requester wins
        // by being assigned last.
        for (int i = N_DOM - 1; i >= 0; i--) begin
            cand = int'(ptr) + i;
            if (cand >= N_DOM) begin
                cand = cand - N_DOM;
            end
            cidx = IW'(cand);
            if (req[cidx]) begin
                grant = cidx;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rstb_sequencer.sv
// Reset sequencer / arbiter for the RSTB pins of the register domains.
// Holds all domains in reset, releases them one at a time, then services
// per-domain soft resets round-robin.
//   CLK      : clock, rising edge
//   RSTB     : synchronous active-low reset
//   start    : one-cycle request to re-run the full sequence (RUN only)
//   soft_req : per-domain soft-reset request level
//   soft_ack : one-cycle pulse when a domain's soft reset completes
//   dom_rstb : registered active-low reset per domain
//   busy     : sequence or soft reset in progress
//   done     : all domains released, block idle
//
// state | meaning
// HOLD  | all domains held low, counting the hold width
// GAP   | releasing domains 1..N_DOM-1, one per stagger interval
// RUN   | idle, all released; accepts start or soft_req
// SOFT  | one granted domain held low for the hold width
module rstb_sequencer
    import rstb_seq_pkg::*;
#(
    parameter int N_DOM          = 4,
    parameter int HOLD_CYCLES    = 8,
    parameter int STAGGER_CYCLES = 2
) (
    input  logic             CLK,
    input  logic             RSTB,
    input  logic             start,
    input  logic [N_DOM-1:0] soft_req,
    output logic [N_DOM-1:0] soft_ack,
    output logic [N_DOM-1:0] dom_rstb,
    output logic             busy,
    output logic             done
);

    localparam int CW = cnt_width(HOLD_CYCLES, STAGGER_CYCLES);
    localparam int IW = $clog2(N_DOM);

    localparam logic [1:0] S_HOLD = ST_HOLD;
    localparam logic [1:0] S_GAP  = ST_GAP;
    localparam logic [1:0] S_RUN  = ST_RUN;
    localparam logic [1:0] S_SOFT = ST_SOFT;

    localparam logic [CW-1:0] HOLD_TC = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] STAG_TC = CW'(STAGGER_CYCLES - 1);
    localparam logic [IW-1:0] LAST    = IW'(N_DOM - 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] soft_g;
    logic [IW-1:0] arb_grant;
    logic          arb_valid;

    rstb_rr_arbiter #(
        .N_DOM (N_DOM),
        .IW    (IW)
    ) u_arb (
        .req   (soft_req),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    always_ff @(posedge CLK) begin
        if (!RSTB) begin
            state    <= S_HOLD;
            cnt      <= '0;
            idx      <= '0;
            rr_ptr   <= '0;
            soft_g   <= '0;
            dom_rstb <= '0;
            soft_ack <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
        end else begin
            soft_ack <= '0;
            case (state)
                S_HOLD: begin
                    if (cnt == HOLD_TC) begin
                        dom_rstb[0] <= 1'b1;
                        idx         <= IW'(1);
                        cnt         <= '0;
                        state       <= S_GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt == STAG_TC) begin
                        dom_rstb[idx] <= 1'b1;
                        cnt           <= '0;
                        if (idx == LAST) begin
                            state <= S_RUN;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (start) begin
                        dom_rstb <= '0;
                        done     <= 1'b0;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        idx      <= '0;
                        state    <= S_HOLD;
                    end else if (arb_valid) begin
                        dom_rstb[arb_grant] <= 1'b0;
                        soft_g              <= arb_grant;
                        busy                <= 1'b1;
                        done                <= 1'b0;
                        cnt                 <= '0;
                        state               <= S_SOFT;
                    end
                end
                S_SOFT: begin
                    if (cnt == HOLD_TC) begin
                        dom_rstb[soft_g] <= 1'b1;
                        soft_ack[soft_g] <= 1'b1;
                        rr_ptr           <= (soft_g == LAST) ? '0 : soft_g + 1'b1;
                        busy             <= 1'b0;
                        done             <= 1'b1;
                        state            <= S_RUN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_HOLD;
            endcase
        end
    end

endmodule
